// File: rtl/rr_elastic_arbiter.sv
// rr_elastic_arbiter: N-way round-robin arbiter feeding one srdy/rrdy channel
// through a 1-entry full-throughput output register. Packets (runs of beats
// ending with in_last=1) are never interleaved: once a multi-beat packet starts,
// only its owner is served until its last beat is accepted.
module rr_elastic_arbiter #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int ID_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    in_srdy,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_last,
  output logic [N-1:0]    in_rrdy,
  output logic            out_srdy,
  input  logic            out_rrdy,
  output logic [W-1:0]    out_data,
  output logic [ID_W-1:0] out_src,
  output logic            out_last
);

  // Request vectors are widened to the full ID space so any ID_W-bit index is
  // in range; unused slots read as idle.
  localparam int NP = 1 << ID_W;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t          r_state;
  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] r_lock_id;
  logic            r_full;
  logic [W-1:0]    r_data;
  logic [ID_W-1:0] r_src;
  logic            r_last;

  logic [NP-1:0]   w_srdy_pad;
  logic [NP-1:0]   w_last_pad;
  logic [NP-1:0]   w_rrdy_pad;
  logic [W-1:0]    w_data_pad [NP];
  logic            w_load_en;
  logic            w_arb_found;
  logic [ID_W-1:0] w_arb_idx;
  logic [ID_W-1:0] w_sel;
  logic            w_sel_act;
  logic            w_xfer;

  // (base + off) mod N for base < N and off <= N; correct for non-power-of-two N.
  function automatic logic [ID_W-1:0] f_wrap_add(input logic [ID_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N) s = s - N;
    return ID_W'(s);
  endfunction

  for (genvar gi = 0; gi < NP; gi++) begin : g_pad
    if (gi < N) begin : g_real
      assign w_srdy_pad[gi] = in_srdy[gi];
      assign w_last_pad[gi] = in_last[gi];
      assign w_data_pad[gi] = in_data[gi*W +: W];
    end else begin : g_idle
      assign w_srdy_pad[gi] = 1'b0;
      assign w_last_pad[gi] = 1'b0;
      assign w_data_pad[gi] = '0;
    end
  end

  // Rotating-priority search: first requesting index at or after r_ptr wins.
  always_comb begin
    w_arb_found = 1'b0;
    w_arb_idx   = '0;
    for (int k = 0; k < N; k++) begin
      if (!w_arb_found && w_srdy_pad[f_wrap_add(r_ptr, k)]) begin
        w_arb_found = 1'b1;
        w_arb_idx   = f_wrap_add(r_ptr, k);
      end
    end
  end

  // Pick the served requester and raise its accept when the register can load.
  // While locked the owner's accept is offered even if it is idle, so other
  // requesters cannot slip a beat into the middle of the packet.
  always_comb begin
    w_load_en = !r_full | out_rrdy;
    if (r_state == ST_LOCK) begin
      w_sel     = r_lock_id;
      w_sel_act = 1'b1;
    end else begin
      w_sel     = w_arb_idx;
      w_sel_act = w_arb_found;
    end
    w_rrdy_pad        = '0;
    w_rrdy_pad[w_sel] = w_sel_act & w_load_en;
    w_xfer            = w_sel_act & w_load_en & w_srdy_pad[w_sel];
  end

  // Output register: load on every transfer, empty when drained without refill.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= 1'b0;
      r_data <= '0;
      r_src  <= '0;
      r_last <= 1'b0;
    end else if (w_xfer) begin
      r_full <= 1'b1;
      r_data <= w_data_pad[w_sel];
      r_src  <= w_sel;
      r_last <= w_last_pad[w_sel];
    end else if (out_rrdy) begin
      r_full <= 1'b0;
    end
  end

  // Arbitration FSM: lock on a non-last beat, advance the pointer past the
  // source of every completed packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_ARB;
      r_ptr     <= '0;
      r_lock_id <= '0;
    end else if (w_xfer) begin
      if (w_last_pad[w_sel]) begin
        r_ptr   <= f_wrap_add(w_sel, 1);
        r_state <= ST_ARB;
      end else begin
        r_lock_id <= w_sel;
        r_state   <= ST_LOCK;
      end
    end
  end

  assign in_rrdy  = w_rrdy_pad[N-1:0];
  assign out_srdy = r_full;
  assign out_data = r_data;
  assign out_src  = r_src;
  assign out_last = r_last;

endmodule

// File: tb/tb_rr_elastic_arbiter.sv
// Bench for rr_elastic_arbiter: one N=4 and one N=3 instance run in lockstep
// against a behavioural arbiter model, with directed sequences and a random run.
module tb_rr_elastic_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // N=4 instance
  logic       rst4, orrdy4, osrdy4, olast4;
  logic [3:0] srdy4, last4, rrdy4;
  logic [31:0] data4;
  logic [7:0] odata4;
  logic [1:0] osrc4;

  // N=3 instance
  logic       rst3, orrdy3, osrdy3, olast3;
  logic [2:0] srdy3, last3, rrdy3;
  logic [23:0] data3;
  logic [7:0] odata3;
  logic [1:0] osrc3;

  rr_elastic_arbiter #(.N(4), .W(8), .ID_W(2)) u_dut4 (
    .clk(clk), .rst(rst4), .in_srdy(srdy4), .in_data(data4), .in_last(last4),
    .in_rrdy(rrdy4), .out_srdy(osrdy4), .out_rrdy(orrdy4), .out_data(odata4),
    .out_src(osrc4), .out_last(olast4));

  rr_elastic_arbiter #(.N(3), .W(8), .ID_W(2)) u_dut3 (
    .clk(clk), .rst(rst3), .in_srdy(srdy3), .in_data(data3), .in_last(last3),
    .in_rrdy(rrdy3), .out_srdy(osrdy3), .out_rrdy(orrdy3), .out_data(odata3),
    .out_src(osrc3), .out_last(olast3));

  int n_checks = 0;
  int n_errors = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Behavioural model state, index 0 = N4, index 1 = N3.
  bit         m_valid [2];
  bit         m_full  [2];
  logic [7:0] m_data  [2];
  int         m_src   [2];
  bit         m_last  [2];
  int         m_ptr   [2];
  bit         m_lock  [2];
  int         m_lid   [2];
  int         m_acc   [2];

  bit         sb_on;
  int         acc_cnt [2][4];
  int         out_cnt [2][4];
  logic [5:0] exp_seq [2][4];
  logic [5:0] gen_seq [2][4];

  // Compare one instance against the model, then advance the model by one clock.
  task automatic model_step(input int inst, input int n, input logic r,
                            input logic [3:0] srdy, input logic [3:0] last,
                            input logic [31:0] data, input logic orrdy,
                            input logic [3:0] d_rrdy, input logic d_osrdy,
                            input logic d_olast, input logic [7:0] d_odata,
                            input logic [1:0] d_osrc);
    int cand;
    int s;
    bit found;
    bit ld;
    logic [3:0] exp_rrdy;
    if (m_valid[inst])
      chk($sformatf("n%0d_out", n), {20'h0, d_osrdy, d_olast, d_osrc, d_odata},
          {20'h0, m_full[inst], m_last[inst], 2'(m_src[inst]), m_data[inst]});
    if (sb_on && m_valid[inst] && d_osrdy && orrdy) begin
      s = int'(d_osrc);
      chk($sformatf("n%0d_sb", n), {24'h0, d_odata}, {24'h0, d_osrc, exp_seq[inst][s]});
      exp_seq[inst][s]++;
      out_cnt[inst][s]++;
    end
    m_acc[inst] = -1;
    if (r) begin
      m_valid[inst] = 1'b1;
      m_full[inst] = 1'b0; m_data[inst] = 8'h0; m_src[inst] = 0; m_last[inst] = 1'b0;
      m_ptr[inst] = 0; m_lock[inst] = 1'b0; m_lid[inst] = 0;
      return;
    end
    if (!m_valid[inst]) return;
    ld = !m_full[inst] || orrdy;
    found = 1'b0;
    cand = 0;
    if (m_lock[inst]) begin
      found = 1'b1;
      cand = m_lid[inst];
    end else begin
      for (int k = 0; k < n; k++) begin
        if (!found && srdy[(m_ptr[inst] + k) % n]) begin
          found = 1'b1;
          cand = (m_ptr[inst] + k) % n;
        end
      end
    end
    exp_rrdy = (found && ld) ? 4'(1 << cand) : 4'h0;
    chk($sformatf("n%0d_rrdy", n), {28'h0, d_rrdy}, {28'h0, exp_rrdy});
    if (found && ld && srdy[cand]) begin
      m_acc[inst] = cand;
      if (sb_on) acc_cnt[inst][cand]++;
      m_full[inst] = 1'b1;
      m_data[inst] = data[cand*8 +: 8];
      m_src[inst]  = cand;
      m_last[inst] = last[cand];
      if (last[cand]) begin
        m_ptr[inst]  = (cand + 1) % n;
        m_lock[inst] = 1'b0;
      end else begin
        m_lock[inst] = 1'b1;
        m_lid[inst]  = cand;
      end
    end else if (orrdy) begin
      m_full[inst] = 1'b0;
    end
  endtask

  task automatic tick_check();
    @(negedge clk);
    model_step(0, 4, rst4, srdy4, last4, data4, orrdy4, rrdy4, osrdy4, olast4, odata4, osrc4);
    model_step(1, 3, rst3, {1'b0, srdy3}, {1'b0, last3}, {8'h0, data3}, orrdy3,
               {1'b0, rrdy3}, osrdy3, olast3, odata3, osrc3);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic set4(input logic [3:0] s, input logic [3:0] l, input logic o);
    srdy4 = s; last4 = l; orrdy4 = o;
  endtask

  initial begin
    rst4 = 1'b1; rst3 = 1'b1;
    set4(4'h0, 4'h0, 1'b1); data4 = '0;
    srdy3 = '0; last3 = '0; orrdy3 = 1'b1; data3 = '0;
    sb_on = 1'b0;
    for (int i = 0; i < 2; i++) m_valid[i] = 1'b0;
    repeat (2) begin tick_check(); adv(); end
    rst4 = 1'b0; rst3 = 1'b0;

    // Reset state
    tick_check();
    chk("rst_out", {20'h0, osrdy4, olast4, osrc4, odata4}, 32'h0);
    chk("rst_rrdy", {28'h0, rrdy4}, 32'h0);
    adv();

    // N=3 fairness, all single-beat
    data3 = 24'h323130; last3 = 3'b111;
    for (int k = 0; k < 7; k++) begin
      srdy3 = (k < 6) ? 3'b111 : 3'b000;
      tick_check();
      if (k == 0) chk("n3_first_rrdy", {29'h0, rrdy3}, 32'h1);
      if (k >= 1) chk("n3_rot", {22'h0, osrdy3, osrc3, odata3},
                      {22'h0, 1'b1, 2'((k - 1) % 3), 8'(8'h30 + (k - 1) % 3)});
      adv();
    end
    srdy3 = '0;

    // N=4 fairness, all single-beat
    data4 = 32'hA3A2A1A0;
    for (int k = 0; k < 6; k++) begin
      set4((k < 5) ? 4'hF : 4'h0, 4'hF, 1'b1);
      tick_check();
      if (k == 0) chk("rot_first_rrdy", {28'h0, rrdy4}, 32'h1);
      if (k >= 1) chk("rot", {22'h0, osrdy4, osrc4, odata4},
                      {22'h0, 1'b1, 2'((k - 1) % 4), 8'(8'hA0 + (k - 1) % 4)});
      adv();
    end

    // Single requester 2
    data4 = 32'h00220000;
    for (int k = 0; k < 4; k++) begin
      set4((k < 3) ? 4'b0100 : 4'h0, 4'hF, 1'b1);
      tick_check();
      if (k < 3) chk("solo2_rrdy", {28'h0, rrdy4}, 32'h4);
      if (k >= 1) chk("solo2_src", {30'h0, osrc4}, 32'h2);
      adv();
    end

    // Bring pointer to 1 with one beat from requester 0
    data4 = 32'h00000005;
    set4(4'b0001, 4'hF, 1'b1);
    tick_check(); chk("ptr_setup_rrdy", {28'h0, rrdy4}, 32'h1); adv();

    // 3-beat packet on requester 1 with a bubble, 0 and 3 waiting
    data4 = {8'h3A, 8'h00, 8'h11, 8'h0A};
    set4(4'b1011, 4'b1001, 1'b1);
    tick_check(); chk("pkt_b0_rrdy", {28'h0, rrdy4}, 32'h2); adv();
    data4[15:8] = 8'h12;
    tick_check(); chk("pkt_b1_rrdy", {28'h0, rrdy4}, 32'h2);
    chk("pkt_b1_out", {22'h0, osrdy4, osrc4, odata4}, {22'h0, 1'b1, 2'd1, 8'h11}); adv();
    set4(4'b1001, 4'b1001, 1'b1);
    tick_check(); chk("pkt_bubble_rrdy", {28'h0, rrdy4}, 32'h2);
    chk("pkt_b2_out", {22'h0, osrdy4, osrc4, odata4}, {22'h0, 1'b1, 2'd1, 8'h12}); adv();
    data4[15:8] = 8'h13;
    set4(4'b1011, 4'b1011, 1'b1);
    tick_check(); chk("pkt_bubble_out", {31'h0, osrdy4}, 32'h0);
    chk("pkt_last_rrdy", {28'h0, rrdy4}, 32'h2); adv();
    set4(4'b1001, 4'b1001, 1'b1);
    tick_check(); chk("pkt_next3", {28'h0, rrdy4}, 32'h8);
    chk("pkt_b3_out", {21'h0, osrdy4, olast4, osrc4, odata4}, {21'h0, 1'b1, 1'b1, 2'd1, 8'h13}); adv();
    tick_check(); chk("pkt_next0", {28'h0, rrdy4}, 32'h1); adv();
    set4(4'h0, 4'hF, 1'b1);
    tick_check(); chk("pkt_tail_src", {30'h0, osrc4}, 32'h0); adv();

    // Backpressure with all four pending
    data4 = 32'hA3A2A1A0;
    set4(4'hF, 4'hF, 1'b0);
    tick_check(); chk("bp_first_rrdy", {28'h0, rrdy4}, 32'h2); adv();
    for (int k = 0; k < 4; k++) begin
      tick_check();
      chk("bp_hold_rrdy", {28'h0, rrdy4}, 32'h0);
      chk("bp_hold_out", {23'h0, osrdy4, odata4}, {23'h0, 1'b1, 8'hA1});
      adv();
    end
    orrdy4 = 1'b1;
    tick_check(); chk("bp_refill_rrdy", {28'h0, rrdy4}, 32'h4); adv();
    tick_check(); chk("bp_refill_out", {22'h0, osrc4, odata4}, {22'h0, 2'd2, 8'hA2}); adv();
    set4(4'h0, 4'hF, 1'b1);
    tick_check(); adv();

    // Reset while locked on requester 2 with the register full
    data4 = 32'h00210000;
    set4(4'b0100, 4'b0000, 1'b1);
    tick_check(); chk("lk_rrdy", {28'h0, rrdy4}, 32'h4); adv();
    data4 = 32'h00220000;
    set4(4'b0100, 4'b0000, 1'b0);
    rst4 = 1'b1;
    tick_check(); chk("lk_full", {31'h0, osrdy4}, 32'h1); adv();
    rst4 = 1'b0;
    data4 = 32'h0000B1B0;
    set4(4'b0011, 4'b0011, 1'b1);
    tick_check(); chk("lk_after_rst_srdy", {31'h0, osrdy4}, 32'h0);
    chk("lk_after_rst_rrdy", {28'h0, rrdy4}, 32'h1); adv();
    set4(4'h0, 4'hF, 1'b1);
    tick_check(); chk("lk_after_rst_out", {22'h0, osrdy4, osrc4, odata4}, {22'h0, 1'b1, 2'd0, 8'hB0}); adv();

    // Random run on both instances with per-source scoreboard
    rst4 = 1'b1; rst3 = 1'b1;
    repeat (2) begin tick_check(); adv(); end
    rst4 = 1'b0; rst3 = 1'b0;
    for (int a = 0; a < 2; a++)
      for (int b = 0; b < 4; b++) begin
        acc_cnt[a][b] = 0; out_cnt[a][b] = 0; exp_seq[a][b] = '0; gen_seq[a][b] = '0;
      end
    sb_on = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      tick_check();
      adv();
      for (int i = 0; i < 4; i++) begin
        if (m_acc[0] == i || !srdy4[i]) begin
          if ($urandom_range(0, 9) < 6) begin
            srdy4[i] = 1'b1;
            data4[i*8 +: 8] = {2'(i), gen_seq[0][i]};
            gen_seq[0][i]++;
            last4[i] = 1'($urandom_range(0, 1));
          end else srdy4[i] = 1'b0;
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (m_acc[1] == i || !srdy3[i]) begin
          if ($urandom_range(0, 9) < 6) begin
            srdy3[i] = 1'b1;
            data3[i*8 +: 8] = {2'(i), gen_seq[1][i]};
            gen_seq[1][i]++;
            last3[i] = 1'($urandom_range(0, 1));
          end else srdy3[i] = 1'b0;
        end
      end
      orrdy4 = ($urandom_range(0, 9) < 7);
      orrdy3 = ($urandom_range(0, 9) < 7);
    end
    for (int a = 0; a < 2; a++)
      for (int b = 0; b < 4; b++)
        chk($sformatf("cnt_i%0d_s%0d", a, b),
            out_cnt[a][b] + ((m_full[a] && m_src[a] == b) ? 1 : 0), acc_cnt[a][b]);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
